regfile_pingpong: RTL
=====================

// Module: regfile_pingpong
// PURPOSE
//  Double-buffered (ping-pong) register file for the img2col path.
//  - Write side fills one bank of REG_NUM words, LANES words per beat, using valid/ready.
//  - A completed bank is presented whole on out[] under valid/ready,
//    while the other bank is filled.
//  - Sits between the pixel fetch stage and the PE-array window input.
// PARAMETERS
//  DATA_W      16                  word width
//  REG_NUM     25                  words per bank (e.g. 5x5 window)
//  LANES       1                   words written per accepted beat (1..REG_NUM)
//  ADDR_W      $clog2(REG_NUM)     write address width
//  CLR_ON_RD   0                   1: zero a bank's words when it is consumed
// PORTS
//  clk        in   1                 clock
//  nrst       in   1                 reset, asynchronous, active-low
//  flush      in   1                 sync: drop both banks, return to reset state
//  wr_valid   in   1                 write beat valid
//  wr_ready   out  1                 write bank can accept a beat
//  wr_addr    in   ADDR_W            first word index of beat
//  wr_data    in   LANES x DATA_W    lane i -> word wr_addr+i
//  wr_last    in   1                 beat completes current bank
//  out_valid  out  1                 a full bank is presented on out
//  out_ready  in   1                 consumer takes presented bank
//  out        out  REG_NUM x DATA_W  all words of the read bank
//  out_bank   out  1                 index (0/1) of bank on out
//  ovf_err    out  1                 sticky: a lane addressed >= REG_NUM
// BEHAVIOUR
//  Reset/flush
//  - Both banks EMPTY, all words 0; wr_sel=0, rd_sel=0.
//  - wr_ready=1, out_valid=0, out_bank=0, ovf_err=0.
//  - flush clears ovf_err. nrst overrides flush.
//  - Reset mid-fill or mid-read discards everything; no partial bank survives.
//  Bank state
//  - Each bank: EMPTY -> FILLING (first accepted beat).
//  - FILLING -> FULL (accepted beat with wr_last); EMPTY -> FULL also allowed on a single-beat bank.
//  - FULL -> EMPTY (out_valid & out_ready).
//  Write side
//  - wr_ready = (state[wr_sel] != FULL). Beat accepted when wr_valid & wr_ready.
//  - Accepted beat writes lane i to bank[wr_sel][wr_addr+i] at the clock edge.
//  - Lanes with wr_addr+i >= REG_NUM are dropped and set ovf_err; other lanes are still written.
//  - Words not written keep their previous value. No completeness check on wr_last.
//  - Accepted wr_last: bank goes FULL and wr_sel toggles at the same edge.
//  - The next beat targets the other bank if it is not FULL.
//  Read side
//  - out_valid = (state[rd_sel] == FULL); out = bank[rd_sel]; out_bank = rd_sel.
//  - All of these are registered state, so there is zero combinational path from the write inputs.
//  - A bank completed at edge N shows out_valid=1 in cycle N+1.
//  - out is stable while out_valid & !out_ready.
//  - Consume: bank -> EMPTY, rd_sel toggles. If CLR_ON_RD=1, the bank's words are zeroed at the same edge.
//  Simultaneous events
//  - Commit on one bank and consume on the other in the same cycle: both take effect.
//  - Both banks FULL: wr_ready=0. A consume that cycle raises wr_ready next cycle (no comb ready path).
//  - wr_valid while !wr_ready: ignored, no state change, no error.
//  - Throughput: one bank per REG_NUM/LANES cycles sustained with out_ready=1, no bubbles.
// TESTING
//  1. Reset: nrst low mid-fill -> out_valid=0, wr_ready=1, every out word 0, ovf_err=0.
//  2. LANES=1, write addr k data 100+k for k=0..24, last on k=24
//     -> out_valid next cycle, out[k]=100+k, out_bank=0.
//  3. Ping-pong: hold out_ready=0; fill bank0 then bank1 -> wr_ready=0.
//     Pulse out_ready -> out_bank 0->1, wr_ready=1 the following cycle.
//  4. LANES=4, wr_addr=23 -> words 23,24 written, lanes 2,3 dropped; ovf_err=1 until flush.
//  5. Same-cycle commit of bank1 and consume of bank0 -> out_valid stays 1, out_bank=1, bank0 EMPTY.
//  6. CLR_ON_RD=1: consume bank0, refill only addr 0 with last
//     -> out[0]=new value, out[1..24]=0.

Source files
------------

// File: rtl/regfile_pingpong.sv
// Double-buffered register file: one bank is filled by write beats while the
// other, once complete, is presented whole on out[] until the consumer takes it.
module regfile_pingpong #(
    parameter int DATA_W    = 16,
    parameter int REG_NUM   = 25,
    parameter int LANES     = 1,
    parameter int ADDR_W    = $clog2(REG_NUM),
    parameter bit CLR_ON_RD = 1'b0
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            flush,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [LANES-1:0][DATA_W-1:0]    wr_data,
    input  logic                            wr_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [REG_NUM-1:0][DATA_W-1:0]  out,
    output logic                            out_bank,
    output logic                            ovf_err
);

    // Wide enough that wr_addr + (LANES-1) never wraps before the range check.
    localparam int IDX_W = ADDR_W + $clog2(LANES) + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    bank_state_t                      state [2];
    logic                             wr_sel;
    logic                             rd_sel;
    logic [REG_NUM-1:0][DATA_W-1:0]   mem [2];

    logic                             wr_accept;
    logic                             rd_take;
    logic [LANES-1:0][IDX_W-1:0]      lane_idx;
    logic [LANES-1:0][ADDR_W-1:0]     lane_wa;
    logic [LANES-1:0]                 lane_ok;

    assign wr_ready  = (state[wr_sel] != FULL);
    assign out_valid = (state[rd_sel] == FULL);
    assign out       = mem[rd_sel];
    assign out_bank  = rd_sel;

    assign wr_accept = wr_valid & wr_ready;
    assign rd_take   = out_valid & out_ready;

    always_comb begin
        lane_idx = '0;
        lane_wa  = '0;
        lane_ok  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i] = IDX_W'(wr_addr) + IDX_W'(i);
            lane_ok[i]  = (lane_idx[i] < IDX_W'(REG_NUM));
            lane_wa[i]  = lane_idx[i][ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (flush) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            // Write and read always target different banks, so both may act in one cycle.
            if (wr_accept) begin
                state[wr_sel] <= wr_last ? FULL : FILLING;
                wr_sel        <= wr_sel ^ wr_last;
                ovf_err       <= ovf_err | ~(&lane_ok);
            end
            if (rd_take) begin
                state[rd_sel] <= EMPTY;
                rd_sel        <= ~rd_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (rd_take && CLR_ON_RD) begin
                mem[rd_sel] <= '0;
            end
            if (wr_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_ok[i]) begin
                        mem[wr_sel][lane_wa[i]] <= wr_data[i];
                    end
                end
            end
        end
    end

endmodule
